// File: rtl/competition_pkg.sv
// Shared definitions for the competition-mode question entry blocks.
// Provides the entry FSM state type, the seven-segment patterns in the
// board encoding, the entry field widths and the helpers that map
// mode/op to digit patterns, op ranges and stored opcodes.
package competition_pkg;

  typedef enum logic [1:0] {S_MODE, S_OP, S_A, S_B} state_t;

  localparam logic [7:0] SEG_D1 = 8'b0110_0000;
  localparam logic [7:0] SEG_D2 = 8'b1101_1010;
  localparam logic [7:0] SEG_D3 = 8'b1111_0010;
  localparam logic [7:0] SEG_D4 = 8'b0110_0110;
  localparam logic [7:0] SEG_D5 = 8'b1011_0110;
  localparam logic [7:0] SEG_A  = 8'b0011_1010;
  localparam logic [7:0] SEG_B  = 8'b0011_1110;

  // Entry layout, MSB->LSB: mode | opc | a | b
  localparam int unsigned MODE_W = 3;
  localparam int unsigned OPC_W  = 2;

  function automatic logic [7:0] seg_digit(input logic [2:0] d);
    case (d)
      3'd1:    return SEG_D1;
      3'd2:    return SEG_D2;
      3'd3:    return SEG_D3;
      3'd4:    return SEG_D4;
      3'd5:    return SEG_D5;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] nops(input logic [2:0] mode);
    case (mode)
      3'd1:    return 3'd3;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Mode 2 op 2 shares the code of op 4 so the judging side decodes it
  // the same way as the four-op modes.
  function automatic logic [1:0] opcode(input logic [2:0] mode, input logic [2:0] op);
    if (mode == 3'd2 && op == 3'd2) return 2'b11;
    return op[1:0] - 2'd1;
  endfunction

endpackage

// File: rtl/button_pulse.sv
// Rising-edge detector for three buttons with one shared lockout counter.
// Ports: clk, reset (async, active-high), en (gates acceptance and holds
// the lockout), btn[2:0] = {exit, confirm, select} levels, press[2:0]
// one-hot pulse for the single accepted press (exit > confirm > select).
module button_pulse #(
  parameter int unsigned LOCKOUT_CYC = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] btn,
  output logic [2:0] press
);

  localparam int unsigned LW = $clog2(LOCKOUT_CYC + 1);

  logic [2:0]    prev;
  logic [2:0]    rise;
  logic [LW-1:0] lock;

  always_comb begin
    rise  = btn & ~prev;
    press = '0;
    if (en && lock == '0) begin
      if (rise[2])      press = 3'b100;
      else if (rise[1]) press = 3'b010;
      else if (rise[0]) press = 3'b001;
    end
  end

  // prev tracks the buttons even while disabled so a level held across
  // en=0 does not surface later as a stale edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      lock <= '0;
    end else begin
      prev <= btn;
      if (|press)                lock <= LW'(LOCKOUT_CYC);
      else if (en && lock != '0) lock <= lock - 1'b1;
    end
  end

endmodule

// File: rtl/question_bank_recorder.sv
// Competition-mode question entry with a DEPTH-entry question bank.
// Ports: clk, reset (async, active-high), en (block active), confirm /
// select / exit buttons, clear_bank pulse, in (operand switches);
// rd_idx -> rd_data/rd_valid registered read port; count/full/empty
// bank status; commit/overflow one-cycle pulses; mode_entered; seg1..seg4
// seven-segment digit patterns (mode, operator, 'a' and 'b' prompts).
module question_bank_recorder
  import competition_pkg::*;
#(
  parameter  int unsigned DEPTH       = 50,
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned LOCKOUT_CYC = 25000000,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1),
  localparam int unsigned ENTRY_W     = 2 * DATA_W + MODE_W + OPC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               confirm,
  input  logic               select,
  input  logic               exit,
  input  logic               clear_bank,
  input  logic [DATA_W-1:0]  in,
  input  logic [CNT_W-1:0]   rd_idx,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               commit,
  output logic               overflow,
  output logic               mode_entered,
  output logic [7:0]         seg1,
  output logic [7:0]         seg2,
  output logic [7:0]         seg3,
  output logic [7:0]         seg4
);

  logic [2:0] press;
  logic       p_exit, p_conf, p_sel;

  button_pulse #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_btn (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .btn   ({exit, confirm, select}),
    .press (press)
  );

  assign p_exit = press[2];
  assign p_conf = press[1];
  assign p_sel  = press[0];

  state_t              state, state_n;
  logic [2:0]          mode, mode_n, op, op_n;
  logic [DATA_W-1:0]   a_q, a_n;
  logic                try_commit;
  logic [ENTRY_W-1:0]  entry_n;
  logic [ENTRY_W-1:0]  mem [DEPTH];

  always_comb begin
    state_n    = state;
    mode_n     = mode;
    op_n       = op;
    a_n        = a_q;
    try_commit = 1'b0;
    case (state)
      S_MODE: begin
        if (p_sel) mode_n = (mode == 3'd5) ? 3'd1 : mode + 3'd1;
        else if (p_conf) begin
          state_n = S_OP;
          op_n    = 3'd1;
        end
      end
      S_OP: begin
        if (p_exit) begin
          state_n = S_MODE;
          op_n    = 3'd1;
        end else if (p_conf) state_n = S_A;
        else if (p_sel) op_n = (op == nops(mode)) ? 3'd1 : op + 3'd1;
      end
      S_A: begin
        if (p_exit) state_n = S_OP;
        else if (p_conf) begin
          a_n = in;
          if (mode == 3'd1) begin
            try_commit = 1'b1;
            state_n    = S_OP;
          end else begin
            state_n = S_B;
          end
        end
      end
      S_B: begin
        if (p_exit) state_n = S_OP;
        else if (p_conf) begin
          try_commit = 1'b1;
          state_n    = S_OP;
        end
      end
      default: state_n = S_MODE;
    endcase
    // Entry is assembled straight from the switches so it lands in the
    // bank on the same edge that accepts the confirm.
    entry_n = {mode, opcode(mode, op),
               (state == S_A) ? in : a_q,
               (state == S_B) ? in : {DATA_W{1'b0}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_MODE;
      mode  <= 3'd1;
      op    <= 3'd1;
      a_q   <= '0;
    end else begin
      state <= state_n;
      mode  <= mode_n;
      op    <= op_n;
      a_q   <= a_n;
    end
  end

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign mode_entered = (state != S_MODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      commit   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      commit   <= 1'b0;
      overflow <= 1'b0;
      if (en && clear_bank) count <= '0;
      else if (try_commit) begin
        if (!full) begin
          count  <= count + 1'b1;
          commit <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Bank storage is deliberately unreset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (try_commit && !(en && clear_bank) && !full) mem[count] <= entry_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (rd_idx < count);
      rd_data  <= (rd_idx < count) ? mem[rd_idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg1 <= SEG_D1;
      seg2 <= '0;
      seg3 <= '0;
      seg4 <= '0;
    end else begin
      seg1 <= seg_digit(mode);
      seg2 <= (state != S_MODE) ? seg_digit(op) : 8'h00;
      seg3 <= (state == S_A || state == S_B) ? SEG_A : 8'h00;
      seg4 <= (state == S_B) ? SEG_B : 8'h00;
    end
  end

endmodule

// File: tb/tb_question_bank_recorder.sv
// Directed bench for question_bank_recorder (DEPTH=4, LOCKOUT_CYC=4).
module tb_question_bank_recorder;

  logic        clk, reset, en, confirm, select, exit, clear_bank;
  logic [7:0]  sw;
  logic [2:0]  rd_idx;
  logic [20:0] rd_data;
  logic        rd_valid, full, empty, commit, overflow, mode_entered;
  logic [2:0]  count;
  logic [7:0]  seg1, seg2, seg3, seg4;

  int tests = 0;
  int fails = 0;
  int n_commit = 0;
  int n_ovf = 0;
  bit seg4_seen = 0;

  question_bank_recorder #(.DEPTH(4), .DATA_W(8), .LOCKOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .en(en), .confirm(confirm), .select(select),
    .exit(exit), .clear_bank(clear_bank), .in(sw), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full),
    .empty(empty), .commit(commit), .overflow(overflow),
    .mode_entered(mode_entered), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (commit)    n_commit++;
    if (overflow)  n_ovf++;
    if (seg4 != 0) seg4_seen = 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mask = {exit, confirm, select}; waits out the lockout afterwards
  task automatic press(input logic [2:0] mask);
    @(negedge clk);
    {exit, confirm, select} = mask;
    @(negedge clk);
    {exit, confirm, select} = 3'b000;
    repeat (5) @(negedge clk);
  endtask

  task automatic read_at(input logic [2:0] idx, input logic [20:0] exp_d,
                         input logic exp_v, input string tag);
    rd_idx = idx;
    @(negedge clk);
    check({tag, "_data"}, 32'(rd_data), 32'(exp_d));
    check({tag, "_valid"}, 32'(rd_valid), 32'(exp_v));
  endtask

  initial begin
    reset = 0; en = 0; confirm = 0; select = 0; exit = 0;
    clear_bank = 0; sw = 0; rd_idx = 0;
    #2 reset = 1;
    repeat (2) @(negedge clk);
    // 1. reset state
    check("rst_seg1", 32'(seg1), 32'h60);
    check("rst_seg2", 32'(seg2), 32'h00);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_mode_entered", 32'(mode_entered), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    reset = 0;
    en = 1;

    // 2. mode cycling and op wrap
    press(3'b001); check("mode2", 32'(seg1), 32'hDA);
    press(3'b001); check("mode3", 32'(seg1), 32'hF2);
    press(3'b001); check("mode4", 32'(seg1), 32'h66);
    press(3'b001); check("mode5", 32'(seg1), 32'hB6);
    press(3'b001); check("mode1", 32'(seg1), 32'h60);
    press(3'b010); check("op_entered", 32'(mode_entered), 1);
    check("op1_seg2", 32'(seg2), 32'h60);
    press(3'b001); press(3'b001);
    check("op3_seg2", 32'(seg2), 32'hF2);
    press(3'b001); check("op_wrap", 32'(seg2), 32'h60);
    press(3'b100); check("exit_mode", 32'(mode_entered), 0);
    check("exit_seg2", 32'(seg2), 32'h00);

    // 3. mode 2, op 2, a=12 b=34
    press(3'b001); press(3'b010); press(3'b001);
    check("m2op2_seg2", 32'(seg2), 32'hDA);
    press(3'b010); check("sa_seg3", 32'(seg3), 32'h3A);
    sw = 8'h12; press(3'b010);
    check("sb_seg4", 32'(seg4), 32'h3E);
    sw = 8'h34; press(3'b010);
    check("m2_commit", n_commit, 1);
    check("m2_count", 32'(count), 1);
    check("m2_back_op_seg3", 32'(seg3), 0);
    read_at(3'd0, {3'd2, 2'b11, 8'h12, 8'h34}, 1'b1, "rd0");

    // 4. mode 1, op 3, a=A5
    seg4_seen = 0;
    press(3'b100);
    repeat (4) press(3'b001);
    check("m1_again", 32'(seg1), 32'h60);
    press(3'b010); press(3'b001); press(3'b001);
    press(3'b010);
    sw = 8'hA5; press(3'b010);
    check("m1_commit", n_commit, 2);
    check("m1_seg4_never", 32'(seg4_seen), 0);
    read_at(3'd1, {3'd1, 2'b10, 8'hA5, 8'h00}, 1'b1, "rd1");

    // 5. fill then overflow, then clear
    press(3'b010); sw = 8'h01; press(3'b010);
    press(3'b010); sw = 8'h02; press(3'b010);
    check("fill_count", 32'(count), 4);
    check("fill_full", 32'(full), 1);
    press(3'b010); sw = 8'h03; press(3'b010);
    check("ovf_pulse", n_ovf, 1);
    check("ovf_no_commit", n_commit, 4);
    check("ovf_count", 32'(count), 4);
    check("ovf_state_op", 32'(mode_entered), 1);
    read_at(3'd3, {3'd1, 2'b10, 8'h02, 8'h00}, 1'b1, "rd3");
    read_at(3'd4, 21'd0, 1'b0, "rd4_beyond");
    clear_bank = 1;
    @(negedge clk);
    clear_bank = 0;
    check("clr_count", 32'(count), 0);
    check("clr_empty", 32'(empty), 1);
    read_at(3'd0, 21'd0, 1'b0, "rd_after_clr");

    // 6. simultaneous edges, lockout, exit in S_B, en gating, reset
    press(3'b011);
    check("simul_sa", 32'(seg3), 32'h3A);
    check("simul_op_kept", 32'(seg2), 32'hF2);
    @(negedge clk); exit = 1;
    @(negedge clk); exit = 0;
    @(negedge clk); confirm = 1;
    @(negedge clk); confirm = 0;
    repeat (6) @(negedge clk);
    check("lockout_drop", 32'(seg3), 0);
    check("lockout_commit", n_commit, 4);
    press(3'b100); press(3'b001); press(3'b010);
    press(3'b010); sw = 8'h10; press(3'b010);
    check("sb_again", 32'(seg4), 32'h3E);
    press(3'b100);
    check("sb_exit_seg4", 32'(seg4), 0);
    check("sb_exit_op", 32'(mode_entered), 1);
    check("sb_exit_nocommit", n_commit, 4);
    check("sb_exit_count", 32'(count), 0);
    press(3'b010); sw = 8'h21; press(3'b010); sw = 8'h43; press(3'b010);
    check("pre_rst_count", 32'(count), 1);
    press(3'b010); press(3'b010);
    en = 0;
    press(3'b100);
    check("en_off_hold", 32'(seg4), 32'h3E);
    en = 1;
    @(negedge clk);
    reset = 1;
    #1;
    check("rst_sb_mode", 32'(mode_entered), 0);
    check("rst_sb_count", 32'(count), 0);
    check("rst_sb_seg4", 32'(seg4), 0);
    check("rst_sb_seg1", 32'(seg1), 32'h60);
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/question_bank_recorder.md
Name: question_bank_recorder

Overview:
- Parametrised successor to the competition-mode question entry block.
- The user steps through mode, operator, operand A and operand B with confirm/select/exit buttons.
- Each finished question is committed into a DEPTH-entry bank. The bank has count/full/empty status, overflow reporting, clear, and a registered random-access read port for the judging/playback side.
- Drives four 7-segment digit patterns in the board's existing encoding and sits under the competition-mode top, gated by `en`.

Parameters:
- DEPTH, 50: number of question entries.
- DATA_W, 8: operand width; entry width ENTRY_W = 2*DATA_W+5.
- LOCKOUT_CYC, 25000000: cycles a button is ignored after an accepted press.
- CNT_W, derived localparam = $clog2(DEPTH+1): width of count; not overridable.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- en, in, 1: block active (competition set mode selected); when 0, buttons are ignored and all state holds.
- confirm, in, 1: button, level, already synchronised.
- select, in, 1: button, level, already synchronised.
- exit, in, 1: button, level, already synchronised.
- clear_bank, in, 1: synchronous pulse that empties the bank.
- in, in, DATA_W: operand switches.
- rd_idx, in, CNT_W: read address.
- rd_data, out, ENTRY_W: entry at rd_idx, registered.
- rd_valid, out, 1: rd_idx < count at sample time, registered.
- count, out, CNT_W: stored entries.
- full, out, 1: count==DEPTH.
- empty, out, 1: count==0.
- commit, out, 1: one-cycle pulse on a successful write.
- overflow, out, 1: one-cycle pulse on a commit attempt while full.
- mode_entered, out, 1: state != S_MODE.
- seg1, out, 8: mode digit.
- seg2, out, 8: operator digit.
- seg3, out, 8: 'a' prompt.
- seg4, out, 8: 'b' prompt.

Behaviour:
- Reset (async, reset=1), all values in effect immediately:
  - state=S_MODE, mode=1, op=1, count=0.
  - rd_data=0, rd_valid=0, commit=0, overflow=0.
  - seg1=0110_0000, seg2=seg3=seg4=0.
  - Bank memory is not reset. Reads at or beyond count return 0.
- Button press acceptance:
  - A press is a rising edge of the button taken while lockout is idle. Accepting it starts a LOCKOUT_CYC lockout shared by all three buttons.
  - If several edges arrive in one cycle, only one is accepted, with priority exit > confirm > select.
  - Edges during lockout, or while en=0, are dropped. Edges are not queued.
- Op range per mode (nops):
  - Mode 1: 3 ops.
  - Mode 2: 2 ops.
  - Modes 3-5: 4 ops.
- FSM states and transitions, evaluated on an accepted press:
  - S_MODE:
    - select: mode 1→2→3→4→5→1.
    - confirm: go to S_OP, op=1.
    - exit: no effect.
  - S_OP:
    - select: op steps 1→…→nops(mode)→1.
    - confirm: go to S_A.
    - exit: go to S_MODE; op resets to 1.
  - S_A:
    - confirm: a latched from `in`.
      - Mode 1: commit with b=0 and return to S_OP.
      - Other modes: go to S_B.
    - exit: go to S_OP and discard the entry.
    - select: ignored.
  - S_B:
    - confirm: b latched from `in`; commit and return to S_OP.
    - exit: go to S_OP and discard the entry.
    - select: ignored.
- Entry format, MSB→LSB:
  - mode[2:0]: binary 1..5.
  - opc[1:0]: op-1, except mode 2 op 2, which encodes 2'b11.
  - a[DATA_W-1:0].
  - b[DATA_W-1:0].
- Commit, in the cycle after the accepted confirm:
  - If count<DEPTH: write to index count, count+1, commit=1 for one cycle.
  - Else: no write, count unchanged, overflow=1 for one cycle. The FSM still returns to S_OP.
- clear_bank:
  - Sets count=0 next cycle, in any state.
  - Takes priority over a same-cycle commit, which is then dropped with no commit or overflow pulse.
  - Does not change the FSM state.
- Read port:
  - 1-cycle latency from rd_idx.
  - rd_data=entry when rd_idx<count, else 0.
  - Reading the index being written in the same cycle returns the old contents (read-before-write).
- Display, registered one cycle after a state/mode/op change:
  - Digit codes: 1=0110_0000, 2=1101_1010, 3=1111_0010, 4=0110_0110, 5=1011_0110.
  - seg1: mode digit in every state.
  - seg2: op digit outside S_MODE, else 0.
  - seg3: 0011_1010 in S_A/S_B, else 0.
  - seg4: 0011_1110 in S_B, else 0.
- Reset mid-entry abandons the partial entry; committed data is lost because count=0.

Decomposition:
- Package competition_pkg:
  - state enum S_MODE/S_OP/S_A/S_B.
  - seven-segment digit constants and the 'a'/'b' prompt constants.
  - nops-per-mode function.
  - opcode mapping function.
  - entry field offset constants.
- Sub-module button_pulse (one instance per button, or one 3-bit instance): rising-edge detect plus the shared lockout counter, parameter LOCKOUT_CYC.

Test Plan (bench uses LOCKOUT_CYC=4, DEPTH=4):
1. Reset → seg1=0110_0000, seg2=0, count=0, empty=1, mode_entered=0.
2. Select ×5 in S_MODE → mode visits 2,3,4,5,1; confirm, select ×2 → seg2=1111_0010, then op wraps to 1 on select ×1 in mode 1.
3. Mode 2 entry: op 2, a=0x12, b=0x34 → commit pulse, rd_idx=0 gives rd_data={3'd2,2'b11,8'h12,8'h34}, rd_valid=1.
4. Mode 1 entry: op 3, a=0xA5 → commit after A, entry {3'd1,2'b10,8'hA5,8'h00}; seg4 never nonzero.
5. Fill 4 entries, then a 5th commit → overflow pulse, count=4, full=1, entry 3 unchanged; clear_bank → count=0, rd_valid=0.
6. Confirm and select edges in the same cycle → only confirm acts; a second edge within 4 cycles is ignored. Exit in S_B → no commit, state S_OP. Reset asserted in S_B → immediate S_MODE, count=0.
